// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and step-map helpers for the character-LCD
// frame writer.
package lcd_pkg;

   localparam logic [7:0]  LCD_CMD_LINE1  = 8'h80;
   localparam logic [7:0]  LCD_CMD_LINE2  = 8'hC0;
   localparam int unsigned LCD_CHARS      = 32;
   localparam logic [5:0]  LCD_LAST_STEP  = 6'd33;
   localparam logic [5:0]  LCD_LINE2_STEP = 6'd17;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      GAP
   } lcd_state_t;

   // Steps 0 and 17 are DDRAM address commands; every other step carries a character.
   function automatic logic step_is_cmd(input logic [5:0] step);
      return (step == 6'd0) || (step == LCD_LINE2_STEP);
   endfunction

   // Data steps 1..16 map to entries 0..15, steps 18..33 to entries 16..31.
   function automatic logic [4:0] step_to_index(input logic [5:0] step);
      logic [5:0] idx;
      idx = (step <= LCD_LINE2_STEP) ? (step - 6'd1) : (step - 6'd2);
      return idx[4:0];
   endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// Avalon-MM write-only link between the frame writer (master) and the
// character-LCD controller (slave).
interface lcd_frame_writer_if;

   logic        lcd_address;
   logic        lcd_chipselect;
   logic        lcd_write;
   logic        lcd_read;
   logic [31:0] lcd_writedata;
   logic        lcd_waitrequest;

   modport master (
      output lcd_address,
      output lcd_chipselect,
      output lcd_write,
      output lcd_read,
      output lcd_writedata,
      input  lcd_waitrequest
   );

   modport slave (
      input  lcd_address,
      input  lcd_chipselect,
      input  lcd_write,
      input  lcd_read,
      input  lcd_writedata,
      output lcd_waitrequest
   );

endinterface

// File: rtl/lcd_frame_buffer.sv
// 32x8 shadow character buffer: synchronous write, combinational read,
// every entry refilled with BLANK_CHAR on reset.
module lcd_frame_buffer
   import lcd_pkg::*;
#(
   parameter logic [7:0] BLANK_CHAR = 8'h20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [4:0] waddr,
   input  logic [7:0] wdata,
   input  logic [4:0] raddr,
   output logic [7:0] rdata
);

   logic [7:0] mem [LCD_CHARS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < LCD_CHARS; i++) begin
            mem[i] <= BLANK_CHAR;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_frame_writer.sv
// Avalon-MM master that redraws a 2x16 shadow frame onto the character LCD
// as 34 single-word writes (line-1 address, 16 chars, line-2 address, 16 chars).
module lcd_frame_writer
   import lcd_pkg::*;
#(
   parameter logic [7:0] BLANK_CHAR   = 8'h20,
   parameter bit         AUTO_REFRESH = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      buf_we,
   input  logic [4:0]                buf_addr,
   input  logic [7:0]                buf_wdata,
   input  logic                      refresh,
   output logic                      busy,
   output logic                      done,
   lcd_frame_writer_if.master        lcd
);

   lcd_state_t state_q, state_d;
   logic [5:0] step_q, step_d;
   logic       pending_q, pending_d;
   logic       done_q, done_d;
   logic       cs_q, cs_d;
   logic       rs_q, rs_d;
   logic [7:0] byte_q, byte_d;

   logic       start;
   logic       load;
   logic [5:0] issue_step;
   logic [7:0] rd_data;

   lcd_frame_buffer #(
      .BLANK_CHAR(BLANK_CHAR)
   ) u_frame_buffer (
      .clk   (clk),
      .reset (reset),
      .we    (buf_we),
      .waddr (buf_addr),
      .wdata (buf_wdata),
      .raddr (step_to_index(issue_step)),
      .rdata (rd_data)
   );

   // Step about to be issued; kept apart from the FSM so the buffer read does
   // not loop back through the next-state logic.
   always_comb begin
      issue_step = '0;
      if (state_q == GAP) begin
         issue_step = step_q + 6'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         step_q    <= '0;
         pending_q <= 1'b0;
         done_q    <= 1'b0;
         cs_q      <= 1'b0;
         rs_q      <= 1'b0;
         byte_q    <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         pending_q <= pending_d;
         done_q    <= done_d;
         cs_q      <= cs_d;
         rs_q      <= rs_d;
         byte_q    <= byte_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      cs_d    = cs_q;
      rs_d    = rs_q;
      byte_d  = byte_q;
      done_d  = 1'b0;
      start   = 1'b0;
      load    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pending_q) begin
               start   = 1'b1;
               load    = 1'b1;
               step_d  = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            // Drop chipselect on the completing edge so the slave does not restart.
            if (!lcd.lcd_waitrequest) begin
               cs_d = 1'b0;
               if (step_q == LCD_LAST_STEP) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            load    = 1'b1;
            step_d  = issue_step;
            state_d = REQ;
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         cs_d = 1'b1;
         rs_d = !step_is_cmd(issue_step);
         if (issue_step == 6'd0) begin
            byte_d = LCD_CMD_LINE1;
         end else if (issue_step == LCD_LINE2_STEP) begin
            byte_d = LCD_CMD_LINE2;
         end else begin
            byte_d = rd_data;
         end
      end
   end

   // A request landing on the start cycle survives so it is not lost.
   always_comb begin
      pending_d = pending_q & ~start;
      if (refresh || (AUTO_REFRESH && buf_we)) begin
         pending_d = 1'b1;
      end
   end

   assign busy               = (state_q != IDLE);
   assign done               = done_q;
   assign lcd.lcd_address    = rs_q;
   assign lcd.lcd_chipselect = cs_q;
   assign lcd.lcd_write      = cs_q;
   assign lcd.lcd_read       = 1'b0;
   assign lcd.lcd_writedata  = {24'h0, byte_q};

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer against a waitrequest-stalling LCD slave model.
module tb_lcd_frame_writer;

   logic       clk;
   logic       reset;
   logic       buf_we;
   logic [4:0] buf_addr;
   logic [7:0] buf_wdata;
   logic       refresh;
   logic       busy;
   logic       done;

   lcd_frame_writer_if lcd_bus ();

   lcd_frame_writer #(
      .BLANK_CHAR   (8'h20),
      .AUTO_REFRESH (1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .buf_we    (buf_we),
      .buf_addr  (buf_addr),
      .buf_wdata (buf_wdata),
      .refresh   (refresh),
      .busy      (busy),
      .done      (done),
      .lcd       (lcd_bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [8:0] txn_log [$];
   logic [7:0] frame [32];
   int         wait_cycles = 3;
   int         done_cnt = 0;

   // Slave: stalls wait_cycles-1 cycles, then one waitrequest=0 completion cycle.
   initial begin : slave_model
      int         cnt;
      logic [8:0] cap;
      logic       hold_bad;
      cnt = 0;
      cap = '0;
      hold_bad = 1'b0;
      lcd_bus.lcd_waitrequest = 1'b1;
      forever begin
         @(negedge clk);
         if (reset) begin
            lcd_bus.lcd_waitrequest = 1'b1;
            cnt = 0;
         end else if (!lcd_bus.lcd_waitrequest) begin
            check_eq("gap_cs_low", 32'(lcd_bus.lcd_chipselect), 32'd0);
            lcd_bus.lcd_waitrequest = 1'b1;
         end else if (lcd_bus.lcd_chipselect) begin
            if (cnt == 0) begin
               cap = {lcd_bus.lcd_address, lcd_bus.lcd_writedata[7:0]};
               hold_bad = 1'b0;
            end else if ({lcd_bus.lcd_address, lcd_bus.lcd_writedata[7:0]} != cap
                         || !lcd_bus.lcd_write) begin
               hold_bad = 1'b1;
            end
            cnt++;
            if (cnt >= wait_cycles) begin
               lcd_bus.lcd_waitrequest = 1'b0;
               cnt = 0;
               txn_log.push_back(cap);
               check_eq("hold_const", 32'(hold_bad), 32'd0);
               check_eq("wdata_hi_zero", 32'(lcd_bus.lcd_writedata[31:8]), 32'd0);
               check_eq("write_eq_cs", 32'(lcd_bus.lcd_write), 32'd1);
               check_eq("read_zero", 32'(lcd_bus.lcd_read), 32'd0);
            end
         end
      end
   end

   initial begin : done_monitor
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            check_eq("done_busy_low", 32'(busy), 32'd0);
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic blank_frame();
      for (int i = 0; i < 32; i++) frame[i] = 8'h20;
   endtask

   task automatic write_char(input logic [4:0] a, input logic [7:0] d);
      buf_we = 1'b1;
      buf_addr = a;
      buf_wdata = d;
      frame[a] = d;
      @(negedge clk);
      buf_we = 1'b0;
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   task automatic wait_txns(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (!(txn_log.size() >= n && !busy) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_eq({tag, "_timeout"}, 32'(k >= budget), 32'd0);
      repeat (20) @(negedge clk);
      check_eq({tag, "_txn_count"}, 32'(txn_log.size()), 32'(n));
   endtask

   task automatic check_frames(input int nframes, input string tag);
      logic [8:0] exp;
      int         idx;
      for (int f = 0; f < nframes; f++) begin
         for (int s = 0; s < 34; s++) begin
            if (s == 0)       exp = {1'b0, 8'h80};
            else if (s == 17) exp = {1'b0, 8'hC0};
            else if (s < 17)  exp = {1'b1, frame[s-1]};
            else              exp = {1'b1, frame[s-2]};
            idx = f * 34 + s;
            if (idx < txn_log.size()) begin
               check_eq($sformatf("%s_f%0d_s%0d_rs", tag, f, s), 32'(txn_log[idx][8]), 32'(exp[8]));
               check_eq($sformatf("%s_f%0d_s%0d_byte", tag, f, s), 32'(txn_log[idx][7:0]), 32'(exp[7:0]));
            end
         end
      end
   endtask

   task automatic clear_log();
      txn_log.delete();
      done_cnt = 0;
   endtask

   initial begin : main
      int k;
      reset = 1'b1;
      buf_we = 1'b0;
      buf_addr = '0;
      buf_wdata = '0;
      refresh = 1'b0;
      blank_frame();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_cs", 32'(lcd_bus.lcd_chipselect), 32'd0);
      check_eq("rst_write", 32'(lcd_bus.lcd_write), 32'd0);
      check_eq("rst_address", 32'(lcd_bus.lcd_address), 32'd0);
      check_eq("rst_writedata", lcd_bus.lcd_writedata, 32'd0);
      check_eq("rst_read", 32'(lcd_bus.lcd_read), 32'd0);

      // Blank redraw with start-latency check
      clear_log();
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
      check_eq("lat_cs_edgeN", 32'(lcd_bus.lcd_chipselect), 32'd0);
      check_eq("lat_busy_edgeN", 32'(busy), 32'd0);
      @(negedge clk);
      check_eq("lat_cs_edgeN1", 32'(lcd_bus.lcd_chipselect), 32'd1);
      check_eq("lat_busy_edgeN1", 32'(busy), 32'd1);
      check_eq("first_cmd", lcd_bus.lcd_writedata, 32'h80);
      check_eq("first_rs", 32'(lcd_bus.lcd_address), 32'd0);
      wait_txns(34, 600, "blank");
      check_eq("blank_done_cnt", 32'(done_cnt), 32'd1);
      check_frames(1, "blank");

      // Auto-refresh from buffer writes; writes during the redraw force one more
      clear_log();
      write_char(5'd0, 8'h48);
      write_char(5'd1, 8'h45);
      write_char(5'd2, 8'h4C);
      write_char(5'd3, 8'h4C);
      write_char(5'd4, 8'h4F);
      write_char(5'd16, 8'h57);
      write_char(5'd17, 8'h4F);
      write_char(5'd18, 8'h52);
      write_char(5'd19, 8'h4C);
      write_char(5'd20, 8'h44);
      wait_txns(68, 1500, "hello");
      check_eq("hello_done_cnt", 32'(done_cnt), 32'd2);
      check_frames(2, "hello");

      // Long stall on the first transaction
      clear_log();
      wait_cycles = 500;
      pulse_refresh();
      repeat (200) @(negedge clk);
      check_eq("stall_cs", 32'(lcd_bus.lcd_chipselect), 32'd1);
      check_eq("stall_write", 32'(lcd_bus.lcd_write), 32'd1);
      check_eq("stall_data", lcd_bus.lcd_writedata, 32'h80);
      check_eq("stall_no_txn", 32'(txn_log.size()), 32'd0);
      k = 0;
      while (txn_log.size() < 1 && k < 700) begin
         @(negedge clk);
         k++;
      end
      check_eq("stall_timeout", 32'(k >= 700), 32'd0);
      wait_cycles = 3;
      wait_txns(34, 600, "stall");
      check_eq("stall_done_cnt", 32'(done_cnt), 32'd1);
      check_frames(1, "stall");

      // Two refreshes mid-redraw collapse into one extra redraw
      clear_log();
      pulse_refresh();
      repeat (10) @(negedge clk);
      pulse_refresh();
      repeat (30) @(negedge clk);
      pulse_refresh();
      wait_txns(68, 1500, "dbl");
      check_eq("dbl_done_cnt", 32'(done_cnt), 32'd2);
      check_frames(2, "dbl");

      // Reset while step 10 is outstanding
      clear_log();
      pulse_refresh();
      k = 0;
      while (!(txn_log.size() == 10 && lcd_bus.lcd_chipselect) && k < 500) begin
         @(negedge clk);
         k++;
      end
      check_eq("step10_timeout", 32'(k >= 500), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check_eq("midrst_cs", 32'(lcd_bus.lcd_chipselect), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_done", 32'(done), 32'd0);
      check_eq("midrst_writedata", lcd_bus.lcd_writedata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      blank_frame();
      clear_log();
      repeat (20) @(negedge clk);
      check_eq("midrst_no_resume", 32'(txn_log.size()), 32'd0);
      check_eq("midrst_idle", 32'(busy), 32'd0);
      pulse_refresh();
      wait_txns(34, 600, "postrst");
      check_eq("postrst_done_cnt", 32'(done_cnt), 32'd1);
      check_frames(1, "postrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_frame_writer.md
# lcd_frame_writer

Avalon-MM master that keeps a 32-character shadow frame buffer (2 lines × 16) and streams it to the character-LCD Avalon slave. On each refresh it issues 34 single-word write transactions: a line-1 DDRAM address command, 16 data writes, a line-2 address command, and 16 more data writes. It sits directly upstream of the character LCD controller. User logic writes characters into the buffer and never handles LCD busy polling or command encoding.

## Interface
Parameters:
- BLANK_CHAR, 8'h20: value loaded into every buffer entry on reset.
- AUTO_REFRESH, 1: when 1, every buffer write also sets the refresh request.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- buf_we  in  1  buffer write strobe
- buf_addr  in  5  character index; 0–15 is line 1, 16–31 is line 2
- buf_wdata  in  8  character code
- refresh  in  1  single-cycle request for a full redraw
- busy  out  1  high while a redraw is in progress
- done  out  1  one-cycle pulse when the last transaction of a redraw completes
- lcd_address  out  1  0 = command, 1 = data (drives the slave's RS)
- lcd_chipselect  out  1  transaction request
- lcd_write  out  1  write qualifier; equal to lcd_chipselect
- lcd_read  out  1  tied to 0
- lcd_writedata  out  32  {24'h0, byte}
- lcd_waitrequest  in  1  slave stall; low for exactly one cycle at completion

## Operation
- Frame buffer: 32×8 registers. On reset, all entries = BLANK_CHAR. A write happens when buf_we=1; writes are accepted in every state.
- Pending flag:
  - Set by refresh, or by buf_we when AUTO_REFRESH=1.
  - Cleared when a redraw starts.
  - A request arriving during a redraw stays set and causes exactly one more redraw afterwards.
- Step counter s, 6 bits, range 0..33:
  - s=0: command 8'h80, address=0.
  - s=1..16: data buf[s-1], address=1.
  - s=17: command 8'hC0, address=0.
  - s=18..33: data buf[s-2], address=1.
- Snapshot rule: a character byte is read from the buffer when its transaction is issued (entry to REQ). Writes to entries not yet sent appear in the current redraw.
- FSM states: IDLE, REQ, GAP.
  - IDLE → REQ when pending=1. On this transition: s=0, pending cleared.
  - REQ: chipselect, write, address and writedata are held constant. Leave when waitrequest=0 is sampled.
    - If s=33: go to IDLE and pulse done.
    - Otherwise: go to GAP.
  - GAP: chipselect=0 for one cycle, s increments, then go to REQ.
- Why chipselect must drop: the slave restarts a transfer whenever chipselect is high in its idle state. The master therefore deasserts chipselect on the same edge at which it samples waitrequest=0.
- Slave initialisation: while the slave is initialising, waitrequest stays high. The master simply holds REQ; no timeout.
- busy = (state != IDLE).
- Reset mid-redraw:
  - Next edge: state=IDLE, chipselect=0, pending=0, buffer = BLANK_CHAR.
  - No partial transaction is resumed.

## Timing
- Reset values: busy=0, done=0, lcd_chipselect=0, lcd_write=0, lcd_address=0, lcd_writedata=0, lcd_read=0.
- All outputs are registered, except lcd_read (constant).
- Start latency: refresh sampled at edge N → chipselect=1 after edge N+1.
- Per transaction: (slave cycles with waitrequest high) + 1 completion cycle + 1 GAP cycle.
- Total redraw: 34 transactions.
- done is high in the cycle immediately after the final waitrequest=0 sample; busy is low in that same cycle.
- refresh and buf_we in the same cycle produce one pending request, not two.
- refresh in the same cycle as done: pending is set; the next redraw starts one cycle later.

## Structure
- Shared package lcd_pkg holds:
  - LCD_CMD_LINE1 = 8'h80, LCD_CMD_LINE2 = 8'hC0
  - LCD_CHARS = 32, LCD_LAST_STEP = 6'd33
  - state enum {IDLE, REQ, GAP}
- One sub-module, lcd_frame_buffer: 32×8 register file with synchronous write, combinational read and reset fill.
- The FSM, step decoder and pending logic live in lcd_frame_writer.

## Test plan
- Reset, then refresh, against a slave model with 3-cycle waitrequest → 34 transactions in the order 0x80, 16×0x20, 0xC0, 16×0x20. Address bits match the step map. done fires exactly once.
- Write "HELLO" to addresses 0..4 and "WORLD" to 16..20 with AUTO_REFRESH=1, then no refresh pulse → automatic redraw. Data bytes are 0x48,0x45,0x4C,0x4C,0x4F, then 11×0x20; line 2 shows 0x57,0x4F,0x52,0x4C,0x44.
- Hold waitrequest high for 500 cycles on the first transaction → chipselect, write and writedata stay constant throughout; no duplicate transaction.
- Pulse refresh twice during a redraw → exactly one additional redraw follows; done pulses twice in total.
- Assert reset during step 10 → the next cycle has chipselect=0 and busy=0, and the buffer reads 0x20 everywhere.
- Check the gap after every completion → chipselect is low for at least one cycle between transactions, and lcd_writedata[31:8] is always 0.
